// File: rtl/universal_register.sv
// N-bit universal register: parallel load, logical/arithmetic shifts and rotates
// by a barrel amount in one cycle, with a registered carry-out and a live zero flag.
module universal_register #(
    parameter int N = 64,
    localparam int SHW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_signal,
    input  logic [2:0]     mode,
    input  logic [SHW-1:0] shamt,
    input  logic           fill_bit,
    input  logic [N-1:0]   data_input,
    output logic [N-1:0]   data_output,
    output logic           carry_out,
    output logic           zero_flag
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    localparam logic [SHW-1:0] KMAX = SHW'(N - 1);

    logic [N-1:0]   data_reg, data_next;
    logic           carry_reg, carry_next;
    logic [SHW-1:0] k;

    // Shifts run on widened vectors: the extra bit beyond the data window
    // catches the last bit pushed out, which becomes the carry.
    logic [2*N:0]   shl_ext, shr_ext, asr_ext;
    logic [2*N-1:0] rol_ext, ror_ext;

    // Out-of-range amounts only exist when N is not a power of two.
    assign k = (int'(shamt) > N - 1) ? KMAX : shamt;

    assign shl_ext = {1'b0, data_reg, {N{fill_bit}}} << k;
    assign shr_ext = {{N{fill_bit}}, data_reg, 1'b0} >> k;
    assign asr_ext = {{N{data_reg[N-1]}}, data_reg, 1'b0} >> k;
    assign rol_ext = {data_reg, data_reg} << k;
    assign ror_ext = {data_reg, data_reg} >> k;

    always_comb begin
        data_next  = data_reg;
        carry_next = carry_reg;
        if (load_signal) begin
            unique case (mode_e'(mode))
                MODE_HOLD: ;
                MODE_LOAD: data_next = data_input;
                MODE_SHL: if (k != '0) begin
                    data_next  = shl_ext[2*N-1:N];
                    carry_next = shl_ext[2*N];
                end
                MODE_SHR: if (k != '0) begin
                    data_next  = shr_ext[N:1];
                    carry_next = shr_ext[0];
                end
                MODE_ROL: if (k != '0) begin
                    data_next  = rol_ext[2*N-1:N];
                    carry_next = rol_ext[N];
                end
                MODE_ROR: if (k != '0) begin
                    data_next  = ror_ext[N-1:0];
                    carry_next = ror_ext[N-1];
                end
                MODE_ASR: if (k != '0) begin
                    data_next  = asr_ext[N:1];
                    carry_next = asr_ext[0];
                end
                MODE_CLEAR: begin
                    data_next  = '0;
                    carry_next = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg  <= '0;
            carry_reg <= 1'b0;
        end else begin
            data_reg  <= data_next;
            carry_reg <= carry_next;
        end
    end

    assign data_output = data_reg;
    assign carry_out   = carry_reg;
    assign zero_flag   = (data_reg == '0);

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register (N = 8): the driver queues hand-computed
// results, the monitor pops and compares one result per clock on the falling edge.
module tb_universal_register;

    localparam int N = 8;
    localparam int SHW = 3;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
    localparam logic [2:0] ROL = 3'b100, ROR = 3'b101, ASR = 3'b110, CLR = 3'b111;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_signal;
    logic [2:0]     mode;
    logic [SHW-1:0] shamt;
    logic           fill_bit;
    logic [N-1:0]   data_input;
    logic [N-1:0]   data_output;
    logic           carry_out;
    logic           zero_flag;

    universal_register #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_signal (load_signal),
        .mode        (mode),
        .shamt       (shamt),
        .fill_bit    (fill_bit),
        .data_input  (data_input),
        .data_output (data_output),
        .carry_out   (carry_out),
        .zero_flag   (zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] data;
        logic         carry;
        logic         zero;
    } exp_t;

    exp_t sb_q[$];
    int   check_count = 0;
    int   pass_count  = 0;

    // Monitor: every queued result is compared at the falling edge after its update.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_count++;
            if (data_output === e.data && carry_out === e.carry && zero_flag === e.zero) begin
                pass_count++;
                $display("ok   %-14s data=%02h carry=%0b zero=%0b", e.name, data_output, carry_out, zero_flag);
            end else begin
                $display("FAIL %-14s got data=%02h carry=%0b zero=%0b, want data=%02h carry=%0b zero=%0b",
                         e.name, data_output, carry_out, zero_flag, e.data, e.carry, e.zero);
            end
        end
    end

    task automatic op(input string nm, input bit rst, input bit ls, input logic [2:0] md,
                      input int sh, input bit fb, input logic [N-1:0] din,
                      input logic [N-1:0] exp_data, input bit exp_carry);
        exp_t e;
        reset       = rst;
        load_signal = ls;
        mode        = md;
        shamt       = SHW'(sh);
        fill_bit    = fb;
        data_input  = din;
        @(posedge clk);
        #1;
        e.name  = nm;
        e.data  = exp_data;
        e.carry = exp_carry;
        e.zero  = (exp_data == '0);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout  simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; load_signal = 1'b0; mode = HOLD; shamt = '0; fill_bit = 1'b0; data_input = '0;
        repeat (2) @(negedge clk);

        //        name             rst ls mode sh fb din    data   carry
        op("reset_over_load",      1, 1, LOAD, 0, 0, 8'hFF, 8'h00, 0);
        op("load_a5",              0, 1, LOAD, 0, 0, 8'hA5, 8'hA5, 0);
        op("shl3_fill1",           0, 1, SHL,  3, 1, 8'h00, 8'h2F, 1);
        op("load_81",              0, 1, LOAD, 0, 0, 8'h81, 8'h81, 1);
        op("ror1",                 0, 1, ROR,  1, 0, 8'h00, 8'hC0, 1);
        op("rol1",                 0, 1, ROL,  1, 0, 8'h00, 8'h81, 1);
        op("load_90",              0, 1, LOAD, 0, 0, 8'h90, 8'h90, 1);
        op("asr2",                 0, 1, ASR,  2, 0, 8'h00, 8'hE4, 0);
        op("load_3c",              0, 1, LOAD, 0, 0, 8'h3C, 8'h3C, 0);
        op("disabled_clear",       0, 0, CLR,  0, 0, 8'h00, 8'h3C, 0);
        op("disabled_load",        0, 0, LOAD, 0, 0, 8'h77, 8'h3C, 0);
        op("clear",                0, 1, CLR,  0, 0, 8'h00, 8'h00, 0);
        op("load_b5",              0, 1, LOAD, 0, 0, 8'hB5, 8'hB5, 0);
        op("shr1_fill0",           0, 1, SHR,  1, 0, 8'h00, 8'h5A, 1);
        op("shr0_nochange",        0, 1, SHR,  0, 1, 8'h00, 8'h5A, 1);
        op("rol0_nochange",        0, 1, ROL,  0, 0, 8'h00, 8'h5A, 1);
        op("hold",                 0, 1, HOLD, 5, 1, 8'hFF, 8'h5A, 1);
        op("shr3_fill1",           0, 1, SHR,  3, 1, 8'h00, 8'hEB, 0);
        op("shl7_fill0",           0, 1, SHL,  7, 0, 8'h00, 8'h80, 1);
        op("asr7",                 0, 1, ASR,  7, 1, 8'h00, 8'hFF, 0);
        op("ror7",                 0, 1, ROR,  7, 0, 8'h00, 8'hFF, 1);
        op("reset_over_shl",       1, 1, SHL,  2, 1, 8'h00, 8'h00, 0);
        op("load_01",              0, 1, LOAD, 0, 0, 8'h01, 8'h01, 0);
        op("rol3",                 0, 1, ROL,  3, 0, 8'h00, 8'h08, 0);
        op("ror4",                 0, 1, ROR,  4, 0, 8'h00, 8'h80, 1);
        op("shr7_fill0",           0, 1, SHR,  7, 0, 8'h00, 8'h01, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            check_count++;
            $display("FAIL drain  %0d results still queued, want 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
